// File: rtl/pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid_reg
//  Purpose  : Parametrised pipeline-stage register with a valid/ready
//             handshake, a 2-entry skid buffer (main + skid), 1 beat/cycle
//             throughput, flush and stall. Optional saturating performance
//             counters, enabled by defining PIPE_STAGE_PERF_CNT_EN.
//  Ports    : clk, reset_n        - clock, async active-low reset
//             in_valid/in_ready/in_data    - upstream handshake + payload
//             out_valid/out_ready/out_data - downstream handshake + payload
//             stall, flush        - output-side freeze, discard-all
//             reg_status          - 00 EMPTY, 01 BUSY, 10 FULL, 11 FLUSHED
//             stall_count, flush_count, bubble_count - perf counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        reg_status,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_BUSY    = 2'b01,
        ST_FULL    = 2'b10,
        ST_FLUSHED = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic                main_valid_q, main_valid_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;

    logic                in_fire;
    logic                out_fire;

    // in_ready depends only on registered state, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready   = !skid_valid_q;
    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign reg_status = state_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready && !stall;

    always_comb begin
        state_d      = state_q;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Flush overrides stall and drops any beat accepted this cycle.
            state_d      = ST_FLUSHED;
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE_DATA;
            skid_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_FLUSHED: begin
                    if (in_fire) begin
                        state_d      = ST_BUSY;
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end else begin
                        state_d      = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_data_d  = in_data;
                    end else if (in_fire) begin
                        // Output blocked: park the new beat in the skid slot.
                        state_d      = ST_FULL;
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (out_fire) begin
                        // out_data keeps the departed beat while invalid.
                        state_d      = ST_EMPTY;
                        main_valid_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d      = ST_BUSY;
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE_DATA;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    // Each counter qualifies on its own condition, flush cycles included,
    // and sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall && main_valid_q && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
            if (!main_valid_q && out_ready && !stall && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_count  = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign bubble_count = bubble_cnt_q;
`else
    assign stall_count  = '0;
    assign flush_count  = '0;
    assign bubble_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid_reg
//  Purpose  : Self-checking bench for pipe_stage_skid_reg. A queue-based
//             reference model predicts every output each cycle; directed
//             scenarios add literal expectations. Counter expectations
//             follow PIPE_STAGE_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid_reg;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;
`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              stall;
    logic              flush;
    logic [1:0]        reg_status;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;
    logic [CNT_W-1:0]  bubble_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (32'h0),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stall        (stall),
        .flush        (flush),
        .reg_status   (reg_status),
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .bubble_count (bubble_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: FIFO of held beats ----------------
    logic [31:0] mq[$];
    logic [31:0] m_last;
    bit          m_flushed;
    int          m_stall, m_flush, m_bubble;

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_last    = 32'h0;
            m_flushed = 1'b0;
            m_stall   = 0;
            m_flush   = 0;
            m_bubble  = 0;
        end else begin
            bit ov, rdy, infire, outfire;
            ov      = (mq.size() > 0);
            rdy     = (mq.size() < 2);
            infire  = in_valid && rdy;
            outfire = ov && out_ready && !stall;
            if (stall && ov)                m_stall  = sat(m_stall);
            if (flush)                      m_flush  = sat(m_flush);
            if (!ov && out_ready && !stall) m_bubble = sat(m_bubble);
            if (flush) begin
                mq.delete();
                m_last    = 32'h0;
                m_flushed = 1'b1;
            end else begin
                m_flushed = 1'b0;
                if (outfire) m_last = mq.pop_front();
                if (infire)  mq.push_back(in_data);
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("m_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
            chk("m_in_ready",  {31'b0, in_ready},  {31'b0, mq.size() < 2});
            chk("m_out_data",  out_data, (mq.size() > 0) ? mq[0] : m_last);
            chk("m_status",    {30'b0, reg_status},
                m_flushed ? 32'd3 : 32'(mq.size()));
            chk("m_stall_cnt",  {28'b0, stall_count},  PERF ? 32'(m_stall)  : 32'd0);
            chk("m_flush_cnt",  {28'b0, flush_count},  PERF ? 32'(m_flush)  : 32'd0);
            chk("m_bubble_cnt", {28'b0, bubble_count}, PERF ? 32'(m_bubble) : 32'd0);
        end
    end

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        cyc(2);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_status",    {30'b0, reg_status}, 32'd0);
        reset_n = 1'b1;
        cyc();

        // 1. streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            cyc();
            chk("t1_data",   out_data, 32'(i));
            chk("t1_status", {30'b0, reg_status}, 32'd1);
            chk("t1_ready",  {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("t1_drain_valid", {31'b0, out_valid}, 32'd0);
        chk("t1_drain_data",  out_data, 32'd8);

        // 2. backpressure with A,B,C
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA; cyc();
        in_data   = 32'hB; cyc();
        in_data   = 32'hC; cyc();
        chk("t2_full_status", {30'b0, reg_status}, 32'd2);
        chk("t2_full_ready",  {31'b0, in_ready}, 32'd0);
        chk("t2_full_data",   out_data, 32'hA);
        chk("t2_model_depth", 32'(mq.size()), 32'd2);
        out_ready = 1'b1;
        cyc();
        chk("t2_B", out_data, 32'hB);
        cyc();
        chk("t2_C", out_data, 32'hC);
        in_valid = 1'b0;
        cyc();
        chk("t2_empty", {31'b0, out_valid}, 32'd0);

        // 3. stall while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11; cyc();
        in_data   = 32'h22; cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stall     = 1'b1;
        cyc(3);
        chk("t3_data",      out_data, 32'h11);
        chk("t3_status",    {30'b0, reg_status}, 32'd2);
        chk("t3_stall_cnt", {28'b0, stall_count}, PERF ? 32'd3 : 32'd0);
        stall = 1'b0;
        cyc();
        chk("t3_drain1", out_data, 32'h22);
        cyc();
        chk("t3_drain2", {31'b0, out_valid}, 32'd0);

        // 4. flush while FULL with upstream beat offered, then while BUSY with in_fire
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h33; cyc();
        in_data   = 32'h44; cyc();
        flush     = 1'b1;
        in_data   = 32'h55;
        cyc();
        chk("t4_valid",     {31'b0, out_valid}, 32'd0);
        chk("t4_data",      out_data, 32'h0);
        chk("t4_status",    {30'b0, reg_status}, 32'd3);
        chk("t4_flush_cnt", {28'b0, flush_count}, PERF ? 32'd1 : 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk("t4_after", {30'b0, reg_status}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h66; cyc();
        flush    = 1'b1;
        in_data  = 32'h77; cyc();
        chk("t4b_status", {30'b0, reg_status}, 32'd3);
        chk("t4b_valid",  {31'b0, out_valid}, 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        cyc();

        // 5. bubble counter saturation
        out_ready = 1'b1;
        cyc(20);
        chk("t5_bubble_sat", {28'b0, bubble_count}, PERF ? 32'd15 : 32'd0);
        cyc(5);
        chk("t5_bubble_hold", {28'b0, bubble_count}, PERF ? 32'd15 : 32'd0);

        // 6. asynchronous reset mid-transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h81; cyc();
        in_data   = 32'h82; cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid",  {31'b0, out_valid}, 32'd0);
        chk("t6_ready",  {31'b0, in_ready}, 32'd1);
        chk("t6_status", {30'b0, reg_status}, 32'd0);
        chk("t6_cnt",    {28'b0, bubble_count | stall_count | flush_count}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h99;
        @(posedge clk);
        #1;
        chk("t6_accept", out_data, 32'h99);
        in_valid = 1'b0;
        cyc();

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
